// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_pkg                                                           |
// | Shared op encodings, sequencer states and default sizes.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package matrix_pkg;

  localparam int DEF_MAX_DIM    = 5;
  localparam int DEF_MAX_STORE  = 2;
  localparam int DEF_ELEM_WIDTH = 8;

  localparam logic [1:0] OP_ELEMWISE  = 2'b00;
  localparam logic [1:0] OP_TRANSPOSE = 2'b01;
  localparam logic [1:0] OP_MATMUL    = 2'b10;
  localparam logic [1:0] OP_RESERVED  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_RD_A    = 3'd2,
    ST_RD_B    = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_index_walker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_index_walker                                                  |
// | Nested i/j/k counters (k innermost) with first/last/final flags.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module matrix_index_walker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_adv,
  input  logic       i_use_k,
  input  logic [3:0] i_lim_i,
  input  logic [3:0] i_lim_j,
  input  logic [3:0] i_lim_k,
  output logic [3:0] o_i,
  output logic [3:0] o_j,
  output logic [3:0] o_k,
  output logic       o_first,
  output logic       o_last,
  output logic       o_final
);

  logic [3:0] r_i, r_j, r_k;
  logic       w_i_end, w_j_end, w_k_end;

  // Without k, every (i,j) position is a complete group of one pair.
  assign w_k_end = !i_use_k || (r_k == i_lim_k - 4'd1);
  assign w_j_end = (r_j == i_lim_j - 4'd1);
  assign w_i_end = (r_i == i_lim_i - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_adv) begin
      if (!w_k_end) begin
        r_k <= r_k + 4'd1;
      end else begin
        r_k <= '0;
        if (!w_j_end) begin
          r_j <= r_j + 4'd1;
        end else begin
          r_j <= '0;
          r_i <= r_i + 4'd1;
        end
      end
    end
  end

  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_k     = r_k;
  assign o_first = (r_k == 4'd0);
  assign o_last  = w_k_end;
  assign o_final = w_k_end && w_j_end && w_i_end;

endmodule
`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_op_sequencer                                                  |
// | Validates one matrix op and streams operand pairs to the ALU.        |
// | Optional SEQ_ABORT_EN adds an abort input. Rev 1.0                   |
// +----------------------------------------------------------------------+
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int MAX_DIM    = DEF_MAX_DIM,
  parameter int MAX_STORE  = DEF_MAX_STORE,
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int SLOT_BITS  = (MAX_STORE <= 1) ? 1 : $clog2(MAX_STORE),
  parameter int DIM_BITS   = (MAX_DIM <= 1) ? 1 : $clog2(MAX_DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef SEQ_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [SLOT_BITS-1:0]   slot_a,
  input  logic [SLOT_BITS-1:0]   slot_b,
  input  logic [MAX_STORE*4-1:0] stored_m_flat,
  input  logic [MAX_STORE*4-1:0] stored_n_flat,
  input  logic [MAX_STORE-1:0]   slot_valid,
  output logic                   rd_en,
  output logic [SLOT_BITS-1:0]   rd_slot_idx,
  output logic [DIM_BITS-1:0]    rd_row_idx,
  output logic [DIM_BITS-1:0]    rd_col_idx,
  input  logic [ELEM_WIDTH-1:0]  rd_elem,
  input  logic                   rd_elem_valid,
  output logic [ELEM_WIDTH-1:0]  op_a,
  output logic [ELEM_WIDTH-1:0]  op_b,
  output logic [3:0]             op_row,
  output logic [3:0]             op_col,
  output logic                   op_first,
  output logic                   op_last,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [3:0]             res_m,
  output logic [3:0]             res_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  seq_state_t r_state, w_next;

  logic [1:0]            r_op;
  logic [SLOT_BITS-1:0]  r_slot_a, r_slot_b;
  logic [3:0]            r_ma, r_na, r_mb, r_nb;
  logic [ELEM_WIDTH-1:0] r_op_a, r_op_b;
  logic [3:0]            r_op_row, r_op_col, r_res_m, r_res_n;
  logic                  r_op_first, r_op_last;

  logic       w_abort, w_clr, w_adv, w_reject, w_dim_zero;
  logic       w_is_tr, w_is_mm, w_is_ew;
  logic [3:0] w_i, w_j, w_k, w_lim_i, w_lim_j;
  logic       w_first, w_last, w_final;
  logic [3:0] w_cur_ma, w_cur_na, w_cur_mb, w_cur_nb;
  logic [3:0] w_m [MAX_STORE];
  logic [3:0] w_n [MAX_STORE];

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  for (genvar g = 0; g < MAX_STORE; g++) begin : g_unpack
    assign w_m[g] = stored_m_flat[g*4 +: 4];
    assign w_n[g] = stored_n_flat[g*4 +: 4];
  end

  assign w_cur_ma = w_m[r_slot_a];
  assign w_cur_na = w_n[r_slot_a];
  assign w_cur_mb = w_m[r_slot_b];
  assign w_cur_nb = w_n[r_slot_b];

  assign w_is_ew = (r_op == OP_ELEMWISE);
  assign w_is_tr = (r_op == OP_TRANSPOSE);
  assign w_is_mm = (r_op == OP_MATMUL);

  // Transpose has no B operand, so B's slot and dimensions are not checked.
  assign w_dim_zero = (w_cur_ma == 4'd0) || (w_cur_na == 4'd0) ||
                      (!w_is_tr && ((w_cur_mb == 4'd0) || (w_cur_nb == 4'd0)));
  assign w_reject   = (r_op == OP_RESERVED) ||
                      !slot_valid[r_slot_a] ||
                      (!w_is_tr && !slot_valid[r_slot_b]) ||
                      w_dim_zero ||
                      (w_is_ew && ((w_cur_ma != w_cur_mb) || (w_cur_na != w_cur_nb))) ||
                      (w_is_mm && (w_cur_na != w_cur_mb));

  assign w_lim_i = w_is_tr ? r_na : r_ma;
  assign w_lim_j = w_is_tr ? r_ma : (w_is_mm ? r_nb : r_na);

  matrix_index_walker u_walker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_adv   (w_adv),
    .i_use_k (w_is_mm),
    .i_lim_i (w_lim_i),
    .i_lim_j (w_lim_j),
    .i_lim_k (r_na),
    .o_i     (w_i),
    .o_j     (w_j),
    .o_k     (w_k),
    .o_first (w_first),
    .o_last  (w_last),
    .o_final (w_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    rd_en       = 1'b0;
    rd_slot_idx = '0;
    rd_row_idx  = '0;
    rd_col_idx  = '0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CHECK;
      ST_CHECK: begin
        w_clr  = 1'b1;
        w_next = w_reject ? ST_ERR : ST_RD_A;
      end
      ST_RD_A: begin
        rd_en       = 1'b1;
        rd_slot_idx = r_slot_a;
        rd_row_idx  = w_is_tr ? w_j[DIM_BITS-1:0] : w_i[DIM_BITS-1:0];
        rd_col_idx  = w_is_tr ? w_i[DIM_BITS-1:0] :
                      (w_is_mm ? w_k[DIM_BITS-1:0] : w_j[DIM_BITS-1:0]);
        if (!rd_elem_valid) w_next = ST_ERR;
        else if (w_is_tr)   w_next = ST_PRESENT;
        else                w_next = ST_RD_B;
      end
      ST_RD_B: begin
        rd_en       = 1'b1;
        rd_slot_idx = r_slot_b;
        rd_row_idx  = w_is_mm ? w_k[DIM_BITS-1:0] : w_i[DIM_BITS-1:0];
        rd_col_idx  = w_j[DIM_BITS-1:0];
        w_next      = rd_elem_valid ? ST_PRESENT : ST_ERR;
      end
      ST_PRESENT: begin
        if (op_ready) begin
          w_adv  = 1'b1;
          w_next = w_final ? ST_DONE : ST_RD_A;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Abort outranks everything, including a handshake in PRESENT.
    if (w_abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
      w_adv  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_slot_a   <= '0;
      r_slot_b   <= '0;
      r_ma       <= '0;
      r_na       <= '0;
      r_mb       <= '0;
      r_nb       <= '0;
      r_res_m    <= '0;
      r_res_n    <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_row   <= '0;
      r_op_col   <= '0;
      r_op_first <= 1'b0;
      r_op_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_slot_a <= slot_a;
            r_slot_b <= slot_b;
          end
        end
        ST_CHECK: begin
          r_ma <= w_cur_ma;
          r_na <= w_cur_na;
          r_mb <= w_cur_mb;
          r_nb <= w_cur_nb;
          if (!w_reject) begin
            r_res_m <= w_is_tr ? w_cur_na : w_cur_ma;
            r_res_n <= w_is_tr ? w_cur_ma : (w_is_mm ? w_cur_nb : w_cur_na);
          end
        end
        ST_RD_A: begin
          r_op_a     <= rd_elem;
          r_op_row   <= w_i;
          r_op_col   <= w_j;
          r_op_first <= w_first;
          r_op_last  <= w_last;
          if (w_is_tr) r_op_b <= '0;
        end
        ST_RD_B: r_op_b <= rd_elem;
        default: ;
      endcase
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_row   = r_op_row;
  assign op_col   = r_op_col;
  assign op_first = r_op_first;
  assign op_last  = r_op_last;
  assign op_valid = (r_state == ST_PRESENT);
  assign res_m    = r_res_m;
  assign res_n    = r_res_n;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign err      = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_op_sequencer                                               |
// | Scoreboard bench with a storage model and a list-based op model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_matrix_op_sequencer;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] r;
    logic [3:0] c;
    logic       f;
    logic       l;
  } pair_t;

  typedef struct packed {
    logic       is_err;
    logic       early;
    logic [3:0] m;
    logic [3:0] n;
  } end_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       slot_a = 1'b0, slot_b = 1'b0;
  logic [7:0] stored_m_flat, stored_n_flat;
  logic [1:0] slot_valid;
  logic       rd_en, rd_elem_valid, op_first, op_last, op_valid, busy, done, err;
  logic       rd_slot_idx;
  logic [2:0] rd_row_idx, rd_col_idx;
  logic [7:0] rd_elem, op_a, op_b;
  logic [3:0] op_row, op_col, res_m, res_n;
  logic       op_ready = 1'b0;
`ifdef SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [7:0] mem [2][8][8];
  logic [3:0] tb_m [2];
  logic [3:0] tb_n [2];
  logic [1:0] sv = 2'b00;

  int  n_checks = 0, n_fail = 0;
  int  cyc = 0, rd_cnt = 0, fault_at = 0, val_err_cyc = 0;
  int  gap_expect = 0, ready_mode = 1;
  bit  fault_on = 1'b0, drop_ok = 1'b0;
  pair_t exp_q[$];
  end_t  end_q[$];

  assign stored_m_flat = {tb_m[1], tb_m[0]};
  assign stored_n_flat = {tb_n[1], tb_n[0]};
  assign slot_valid    = sv;
  assign rd_elem       = mem[rd_slot_idx][rd_row_idx][rd_col_idx];
  assign rd_elem_valid = !(fault_on && rd_en && (rd_cnt == fault_at));

  matrix_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .op(op), .slot_a(slot_a), .slot_b(slot_b),
    .stored_m_flat(stored_m_flat), .stored_n_flat(stored_n_flat), .slot_valid(slot_valid),
    .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
    .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
    .op_a(op_a), .op_b(op_b), .op_row(op_row), .op_col(op_col),
    .op_first(op_first), .op_last(op_last), .op_valid(op_valid), .op_ready(op_ready),
    .res_m(res_m), .res_n(res_n), .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 1)      op_ready = 1'b1;
    else if (ready_mode == 2) op_ready = 1'b0;
    else                      op_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event, expected none (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on every handshake and every done/err pulse.
  initial begin
    pair_t got, held, e;
    end_t  ee;
    bit    stalled = 1'b0, have_hs = 1'b0;
    int    last_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        have_hs = 1'b0;
        continue;
      end
      got = {op_a, op_b, op_row, op_col, op_first, op_last};
      if (stalled) begin
        if (!drop_ok) chk("stall_valid_held", {31'd0, op_valid}, 1);
        if (op_valid) chk("stall_fields_held", {6'd0, got}, {6'd0, held});
      end
      stalled = 1'b0;
      if (op_valid) begin
        if (op_ready) begin
          if (exp_q.size() == 0) fail_now("extra_pair");
          else begin
            e = exp_q.pop_front();
            chk("pair", {6'd0, got}, {6'd0, e});
          end
          if (gap_expect != 0 && have_hs) chk("pair_gap", cyc - last_hs, gap_expect);
          have_hs = 1'b1;
          last_hs = cyc;
        end else begin
          stalled = 1'b1;
          held    = got;
        end
      end
      if (done || err) begin
        if (end_q.size() == 0) fail_now("extra_done_err");
        else begin
          ee = end_q.pop_front();
          chk("end_is_err", {31'd0, err}, {31'd0, ee.is_err});
          if (done) begin
            chk("res_m", {28'd0, res_m}, {28'd0, ee.m});
            chk("res_n", {28'd0, res_n}, {28'd0, ee.n});
            if (gap_expect != 0) chk("done_latency", cyc - last_hs, 1);
          end
          if (err && ee.early) chk("err_latency", cyc, val_err_cyc);
        end
        have_hs = 1'b0;
      end
    end
  end

  // Reference model: the expected pair list built straight from the op definitions.
  task automatic model(input int o, input int sa, input int sb, input int fault_off);
    int    ma, na, mb, nb, lim, rp, rm, rn;
    bit    ok, faulted;
    pair_t lst[$];
    ma = tb_m[sa]; na = tb_n[sa]; mb = tb_m[sb]; nb = tb_n[sb];
    ok = (o != 3) && sv[sa] && (o == 1 || sv[sb]) && ma != 0 && na != 0 &&
         (o == 1 || (mb != 0 && nb != 0));
    if (o == 0 && (ma != mb || na != nb)) ok = 1'b0;
    if (o == 2 && na != mb) ok = 1'b0;
    if (!ok) begin
      end_q.push_back({1'b1, 1'b1, 4'd0, 4'd0});
      return;
    end
    rm = (o == 1) ? na : ma;
    rn = (o == 0) ? na : ((o == 1) ? ma : nb);
    for (int i = 0; i < rm; i++)
      for (int j = 0; j < rn; j++)
        if (o == 0)      lst.push_back({mem[sa][i][j], mem[sb][i][j], 4'(i), 4'(j), 1'b1, 1'b1});
        else if (o == 1) lst.push_back({mem[sa][j][i], 8'd0, 4'(i), 4'(j), 1'b1, 1'b1});
        else
          for (int k = 0; k < na; k++)
            lst.push_back({mem[sa][i][k], mem[sb][k][j], 4'(i), 4'(j), k == 0, k == na - 1});
    lim = lst.size();
    faulted = 1'b0;
    if (fault_off >= 0) begin
      rp = (o == 1) ? 1 : 2;
      if (fault_off / rp < lim) begin
        lim = fault_off / rp;
        faulted = 1'b1;
      end
    end
    for (int p = 0; p < lim; p++) exp_q.push_back(lst[p]);
    end_q.push_back({faulted, 1'b0, 4'(rm), 4'(rn)});
  endtask

  task automatic issue(input int o, input int sa, input int sb);
    @(posedge clk); #1;
    start = 1'b1; op = o[1:0]; slot_a = sa[0]; slot_b = sb[0];
    @(posedge clk); #1;
    start = 1'b0;
    val_err_cyc = cyc + 1;
  endtask

  task automatic run_op(input int o, input int sa, input int sb, input int fault_off);
    int t;
    model(o, sa, sb, fault_off);
    fault_on = (fault_off >= 0);
    fault_at = rd_cnt + fault_off;
    issue(o, sa, sb);
    t = 0;
    // Stray starts and input changes while busy must be ignored.
    while (busy && t < 4000) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 7) == 0);
      op     = 2'($urandom);
      slot_a = 1'($urandom);
      slot_b = 1'($urandom);
      t++;
    end
    start = 1'b0;
    if (busy) fail_now("op_timeout");
    fault_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_slot(input int s, input int m, input int n);
    tb_m[s] = 4'(m);
    tb_n[s] = 4'(n);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[s][r][c] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ops"}, {op_a, op_b, op_row, op_col, op_first, op_last, op_valid, rd_en},
        32'd0);
    chk({name, "_ctl"}, {14'd0, rd_slot_idx, rd_row_idx, rd_col_idx, res_m, res_n, busy, done, err},
        32'd0);
  endtask

  initial begin
    int o, sa, sb, fo, t;
    fill_slot(0, 2, 3);
    fill_slot(1, 2, 3);
    sv = 2'b11;
    #2;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed: elementwise, matmul, transpose with ready tied high.
    ready_mode = 1;
    gap_expect = 3;
    run_op(0, 0, 1, -1);
    fill_slot(1, 3, 2);
    run_op(2, 0, 1, -1);
    gap_expect = 2;
    run_op(1, 0, 0, -1);
    gap_expect = 0;

    // Validation failure: slot 1 empty.
    fill_slot(1, 2, 3);
    sv = 2'b01;
    run_op(2, 0, 1, -1);
    sv = 2'b11;
    run_op(3, 0, 1, -1);

    // Read fault in RD_B of the second pair.
    run_op(0, 0, 1, 3);

    // Randomized ops with ALU stalls.
    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      for (int s = 0; s < 2; s++)
        fill_slot(s, ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5), $urandom_range(1, 5));
      sv = {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
      t  = $urandom_range(0, 9);
      o  = (t < 3) ? 0 : (t < 6) ? 1 : (t < 9) ? 2 : 3;
      sa = $urandom_range(0, 1);
      sb = $urandom_range(0, 1);
      if (sa != sb && $urandom_range(0, 3) != 0) begin
        if (o == 2) tb_m[sb] = tb_n[sa];
        if (o == 0) begin tb_m[sb] = tb_m[sa]; tb_n[sb] = tb_n[sa]; end
      end
      fo = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
      run_op(o, sa, sb, fo);
    end

`ifdef SEQ_ABORT_EN
    // Abort while a pair is stalled in PRESENT.
    sv = 2'b11;
    fill_slot(0, 2, 2);
    fill_slot(1, 2, 2);
    ready_mode = 2;
    drop_ok    = 1'b1;
    model(0, 0, 1, -1);
    issue(0, 0, 1);
    t = 0;
    while (!op_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("abort_reach_present", {31'd0, op_valid}, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    end_q.delete();
    chk("abort_valid_low", {31'd0, op_valid}, 0);
    chk("abort_busy_low", {31'd0, busy}, 0);
    repeat (4) @(posedge clk);
    #1;
    drop_ok    = 1'b0;
    ready_mode = 0;
`endif

    // Asynchronous reset in the middle of a long matmul.
    sv = 2'b11;
    fill_slot(0, 4, 5);
    fill_slot(1, 5, 4);
    model(2, 0, 1, -1);
    issue(2, 0, 1);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    exp_q.delete();
    end_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Recovery after reset.
    fill_slot(0, 3, 3);
    run_op(1, 0, 1, -1);
    run_op(2, 0, 0, -1);

    chk("pairs_outstanding", exp_q.size(), 0);
    chk("ends_outstanding", end_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
